// File: rtl/image_buffer_writer.sv
// Packs an 8-bit byte stream into 32-bit little-endian words for the image buffer write port.
// Handles zero-padded flush at frame end, byte counting and sticky overflow on a full buffer.
module image_buffer_writer #(
   parameter int unsigned WORD_DEPTH = 16384
) (
   input  logic        clock_in,
   input  logic        reset_n_in,
   input  logic        frame_start_in,
   input  logic        frame_end_in,
   input  logic [7:0]  data_in,
   input  logic        data_valid_in,
   output logic [15:0] write_address_out,
   output logic [31:0] write_data_out,
   output logic        write_enable_out,
   output logic        capture_active_out,
   output logic        frame_done_out,
   output logic [16:0] byte_count_out,
   output logic        overflow_out
);

   localparam logic [15:0] DEPTH = 16'(WORD_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t      r_state, w_state;
   logic [15:0] r_addr, w_addr, w_addr_eff;
   logic [1:0]  r_lane, w_lane;
   logic [23:0] r_shift, w_shift;
   logic [31:0] r_wdata, w_wdata;
   logic        r_we, w_we;
   logic [16:0] r_count, w_count;
   logic        r_ovf, w_ovf;
   logic        w_full;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_lane  <= '0;
         r_shift <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_addr  <= w_addr;
         r_lane  <= w_lane;
         r_shift <= w_shift;
         r_wdata <= w_wdata;
         r_we    <= w_we;
         r_count <= w_count;
         r_ovf   <= w_ovf;
      end
   end

   // The address shown during a strobe is the written one; it advances on the edge
   // that ends the strobe, so the effective address folds in a pending increment.
   always_comb begin
      w_addr_eff = r_addr + {15'd0, r_we};
      w_full     = (w_addr_eff >= DEPTH);
      w_state    = r_state;
      w_addr     = w_addr_eff;
      w_lane     = r_lane;
      w_shift    = r_shift;
      w_wdata    = r_wdata;
      w_we       = 1'b0;
      w_count    = r_count;
      w_ovf      = r_ovf;

      if (frame_start_in) begin
         w_state = S_CAPTURE;
         w_addr  = '0;
         w_lane  = '0;
         w_shift = '0;
         w_count = '0;
         w_ovf   = 1'b0;
      end else begin
         case (r_state)
            S_CAPTURE: begin
               if (data_valid_in) begin
                  w_lane = r_lane + 2'd1;
                  if (!w_full) w_count = r_count + 17'd1;
                  case (r_lane)
                     2'd0:    w_shift[7:0]   = data_in;
                     2'd1:    w_shift[15:8]  = data_in;
                     2'd2:    w_shift[23:16] = data_in;
                     default: begin
                        w_shift = '0;
                        if (w_full) begin
                           w_ovf = 1'b1;
                        end else begin
                           w_wdata = {data_in, r_shift};
                           w_we    = 1'b1;
                        end
                     end
                  endcase
               end
               if (frame_end_in) begin
                  if (w_lane == 2'd0) begin
                     w_state = S_DONE;
                  end else if (w_full) begin
                     w_ovf   = 1'b1;
                     w_state = S_DONE;
                  end else begin
                     w_wdata = {8'h00, w_shift};
                     w_we    = 1'b1;
                     w_state = S_FLUSH;
                  end
               end
            end
            S_FLUSH: w_state = S_DONE;
            default: ;
         endcase
      end
   end

   assign write_address_out  = r_addr;
   assign write_data_out     = r_wdata;
   assign write_enable_out   = r_we;
   assign capture_active_out = (r_state == S_CAPTURE) || (r_state == S_FLUSH);
   assign frame_done_out     = (r_state == S_DONE);
   assign byte_count_out     = r_count;
   assign overflow_out       = r_ovf;

endmodule

// File: tb/tb_image_buffer_writer.sv
// Bench for image_buffer_writer: default-depth and 4-word instances share stimulus and
// are compared every cycle against a frame-level byte-count model plus directed checks.
module tb_image_buffer_writer;

   localparam int P_IDLE = 0, P_CAP = 1, P_FLUSH = 2, P_DONE = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic t_start = 1'b0, t_end = 1'b0, t_valid = 1'b0;
   logic [7:0] t_data = 8'h00;

   logic [15:0] b_addr, s_addr;
   logic [31:0] b_data, s_data;
   logic        b_we, s_we, b_act, s_act, b_done, s_done, b_ovf, s_ovf;
   logic [16:0] b_cnt, s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int          m_phase [2] = '{P_IDLE, P_IDLE};
   int          m_n     [2] = '{0, 0};
   int          m_writes[2] = '{0, 0};
   logic [31:0] m_part  [2] = '{32'h0, 32'h0};
   logic [31:0] m_wdata [2] = '{32'h0, 32'h0};
   logic        m_we    [2] = '{1'b0, 1'b0};
   logic        m_ovf   [2] = '{1'b0, 1'b0};

   logic [47:0] q_big[$];
   logic [47:0] q_small[$];

   always #5 clk = ~clk;

   image_buffer_writer u_big (
      .clock_in(clk), .reset_n_in(rst_n), .frame_start_in(t_start), .frame_end_in(t_end),
      .data_in(t_data), .data_valid_in(t_valid), .write_address_out(b_addr),
      .write_data_out(b_data), .write_enable_out(b_we), .capture_active_out(b_act),
      .frame_done_out(b_done), .byte_count_out(b_cnt), .overflow_out(b_ovf)
   );

   image_buffer_writer #(.WORD_DEPTH(4)) u_small (
      .clock_in(clk), .reset_n_in(rst_n), .frame_start_in(t_start), .frame_end_in(t_end),
      .data_in(t_data), .data_valid_in(t_valid), .write_address_out(s_addr),
      .write_data_out(s_data), .write_enable_out(s_we), .capture_active_out(s_act),
      .frame_done_out(s_done), .byte_count_out(s_cnt), .overflow_out(s_ovf)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int depth_of(input int i);
      return (i == 0) ? 16384 : 4;
   endfunction

   // Frame-level model: n bytes seen this frame; word k is stored iff k < depth.
   task automatic model_step(input int i);
      int dep;
      dep = depth_of(i);
      m_we[i] = 1'b0;
      if (t_start) begin
         m_phase[i] = P_CAP; m_n[i] = 0; m_part[i] = 0; m_writes[i] = 0; m_ovf[i] = 1'b0;
      end else if (m_phase[i] == P_CAP) begin
         if (t_valid) begin
            m_part[i] = m_part[i] | (32'(t_data) << (8 * (m_n[i] % 4)));
            m_n[i]++;
            if (m_n[i] % 4 == 0) begin
               if (m_n[i] / 4 <= dep) begin
                  m_we[i] = 1'b1; m_wdata[i] = m_part[i]; m_writes[i]++;
               end else begin
                  m_ovf[i] = 1'b1;
               end
               m_part[i] = 0;
            end
         end
         if (t_end) begin
            m_phase[i] = P_DONE;
            if (m_n[i] % 4 != 0) begin
               if (m_n[i] / 4 < dep) begin
                  m_we[i] = 1'b1; m_wdata[i] = m_part[i]; m_writes[i]++; m_phase[i] = P_FLUSH;
               end else begin
                  m_ovf[i] = 1'b1;
               end
            end
         end
      end else if (m_phase[i] == P_FLUSH) begin
         m_phase[i] = P_DONE;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE; m_n[i] = 0; m_writes[i] = 0; m_part[i] = 0;
            m_wdata[i] = 0; m_we[i] = 1'b0; m_ovf[i] = 1'b0;
         end
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   task automatic cmp_inst(input int i, input string nm, input logic [15:0] a, input logic [31:0] d,
                           input logic we, input logic act, input logic done,
                           input logic [16:0] cnt, input logic ovf);
      int exp_cnt;
      int exp_addr;
      exp_cnt  = (m_n[i] < 4 * depth_of(i)) ? m_n[i] : 4 * depth_of(i);
      exp_addr = m_we[i] ? m_writes[i] - 1 : m_writes[i];
      check_val({nm, "_we"},   64'(we),   64'(m_we[i]));
      check_val({nm, "_addr"}, 64'(a),    64'(exp_addr));
      check_val({nm, "_data"}, 64'(d),    64'(m_wdata[i]));
      check_val({nm, "_act"},  64'(act),  64'(m_phase[i] == P_CAP || m_phase[i] == P_FLUSH));
      check_val({nm, "_done"}, 64'(done), 64'(m_phase[i] == P_DONE));
      check_val({nm, "_cnt"},  64'(cnt),  64'(exp_cnt));
      check_val({nm, "_ovf"},  64'(ovf),  64'(m_ovf[i]));
   endtask

   task automatic compare_all();
      cmp_inst(0, "big", b_addr, b_data, b_we, b_act, b_done, b_cnt, b_ovf);
      cmp_inst(1, "small", s_addr, s_data, s_we, s_act, s_done, s_cnt, s_ovf);
      if (b_we) q_big.push_back({b_addr, b_data});
      if (s_we) q_small.push_back({s_addr, s_data});
   endtask

   task automatic cyc(input logic st, input logic en, input logic v, input logic [7:0] d);
      t_start = st; t_end = en; t_valid = v; t_data = d;
      @(posedge clk);
      @(negedge clk);
      compare_all();
      t_start = 1'b0; t_end = 1'b0; t_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int nb;

      // Reset state
      @(posedge clk); @(posedge clk); @(negedge clk);
      compare_all();
      check_val("rst_outs", {b_addr, b_data, b_we, b_act, b_done, b_cnt, b_ovf}, 64'h0);
      rst_n = 1'b1;
      idle(2);

      // 8 bytes back-to-back, frame_end on its own cycle
      q_big.delete();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         d = 8'(8'h11 * (k + 1));
         cyc(1'b0, 1'b0, 1'b1, d);
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      idle(2);
      check_val("t1_nwr", 64'(q_big.size()), 64'd2);
      if (q_big.size() >= 2) begin
         check_val("t1_w0", 64'(q_big[0]), {16'h0, 16'h0000, 32'h44332211});
         check_val("t1_w1", 64'(q_big[1]), {16'h0, 16'h0001, 32'h88776655});
      end
      check_val("t1_cnt", 64'(b_cnt), 64'd8);
      check_val("t1_done", 64'(b_done), 64'd1);

      // 5 bytes with gaps, end on the 5th byte -> flush
      q_big.delete();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 1; k <= 5; k++) begin
         idle(k % 2 + 1);
         cyc(1'b0, (k == 5), 1'b1, 8'(k));
      end
      idle(3);
      check_val("t2_nwr", 64'(q_big.size()), 64'd2);
      if (q_big.size() >= 2) begin
         check_val("t2_w0", 64'(q_big[0]), {16'h0, 16'h0000, 32'h04030201});
         check_val("t2_w1", 64'(q_big[1]), {16'h0, 16'h0001, 32'h00000005});
      end
      check_val("t2_cnt", 64'(b_cnt), 64'd5);

      // Overflow on the 4-word instance: 20 bytes
      q_small.delete();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom));
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      idle(2);
      check_val("t3_nwr", 64'(q_small.size()), 64'd4);
      for (int k = 0; k < 4; k++)
         if (q_small.size() > k) check_val("t3_addr", 64'(q_small[k][47:32]), 64'(k));
      check_val("t3_ovf", 64'(s_ovf), 64'd1);
      check_val("t3_cnt", 64'(s_cnt), 64'd16);
      check_val("t3_addr_end", 64'(s_addr), 64'd4);

      // Restart mid-capture discards the partial word
      q_big.delete();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom));
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 8'(8'hA0 + k));
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      idle(2);
      check_val("t4_nwr", 64'(q_big.size()), 64'd1);
      if (q_big.size() >= 1) check_val("t4_w0", 64'(q_big[0]), {16'h0, 16'h0000, 32'hA3A2A1A0});
      check_val("t4_cnt", 64'(b_cnt), 64'd4);

      // Asynchronous reset after 2 bytes
      q_big.delete();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h5A);
      cyc(1'b0, 1'b0, 1'b1, 8'hA5);
      #2 rst_n = 1'b0;
      #1;
      check_val("t5_big0", {b_addr, b_data, b_we, b_act, b_done, b_cnt, b_ovf}, 64'h0);
      check_val("t5_small0", {s_addr, s_data, s_we, s_act, s_done, s_cnt, s_ovf}, 64'h0);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) cyc(1'b0, (k == 5), 1'b1, 8'($urandom));
      check_val("t5_nwr", 64'(q_big.size()), 64'd0);
      check_val("t5_cnt", 64'(b_cnt), 64'd0);

      // DONE ignores further bytes
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) cyc(1'b0, (k == 3), 1'b1, 8'($urandom));
      idle(1);
      q_big.delete();
      for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom));
      check_val("t6_nwr", 64'(q_big.size()), 64'd0);
      check_val("t6_cnt", 64'(b_cnt), 64'd4);
      check_val("t6_done", 64'(b_done), 64'd1);

      // Randomized frames, checked every cycle against the model
      for (int f = 0; f < 40; f++) begin
         cyc(1'b1, ($urandom_range(0, 9) == 0), 1'b0, 8'h00);
         nb = $urandom_range(0, 28);
         for (int k = 0; k < nb; k++)
            cyc(($urandom_range(0, 59) == 0), 1'b0, ($urandom_range(0, 3) != 0), 8'($urandom));
         cyc(1'b0, 1'b1, $urandom_range(0, 1) == 1, 8'($urandom));
         for (int k = 0; k < $urandom_range(0, 4); k++)
            cyc(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
